bnn_inst_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the BPU controller decoder. Reads 16-bit

---
 rtl/bnn_pkg.sv | 22 ++
 rtl/bnn_fetch_fifo.sv | 57 +++++
 rtl/bnn_inst_fetch.sv | 146 ++++++++++++++
 tb/tb_bnn_inst_fetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN processing unit: opcode encodings seen by the
// controller decoder and the instruction-fetch state encoding.
package bnn_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_NOP    = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_XNOR   = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_POPCNT = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_THRESH = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_JUMP   = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_HALT   = 5'b11111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/bnn_fetch_fifo.sv
// Small synchronous prefetch FIFO holding instruction words with their PCs.
// Flush empties it in one cycle; storage itself is not reset, only pointers.
module bnn_fetch_fifo #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [PC_W-1:0]   push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [PC_W-1:0]   head_pc,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_data[wr_ptr] <= push_data;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end

  assign head_data = mem_data[rd_ptr];
  assign head_pc   = mem_pc[rd_ptr];

endmodule

// File: rtl/bnn_inst_fetch.sv
// Instruction fetch stage: reads the instruction SRAM, buffers words in a
// prefetch FIFO and hands them to the decoder; handles redirects and HALT.
//
//  state | meaning
//  IDLE  | not fetching; start issues the first read at start_pc
//  RUN   | issuing reads under FIFO credit, pushing returned words
//  STOP  | HALT seen; draining FIFO and discarding the last in-flight read
module bnn_inst_fetch
  import bnn_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int INST_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              isram_en,
  output logic [ADDR_W-1:0] isram_addr,
  input  logic [INST_W-1:0] isram_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_t state, state_nxt;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issue_pc;
  logic [ADDR_W-1:0] rd_pc;
  logic              epoch;
  logic              rd_vld;
  logic              rd_epoch;
  logic              issue;
  logic [CNT_W-1:0]  fifo_count;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;
  logic              has_head;
  logic              redir_act;
  logic              resp_ok;
  logic              resp_halt;
  logic              push;
  logic              pop;
  logic              halt_ret;

  assign has_head  = (fifo_count != '0);
  assign redir_act = redirect && (state != IDLE);
  // A response is only useful while running and only if issued in the current epoch.
  assign resp_ok   = rd_vld && (rd_epoch == epoch) && (state == RUN);
  assign resp_halt = (isram_rdata[INST_W-1 -: OPC_W] == OPC_HALT);
  assign push      = resp_ok && !resp_halt && !redir_act;
  assign halt_ret  = resp_ok && resp_halt && !redir_act;
  assign pop       = has_head && inst_ready;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_pc  = fetch_pc;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          issue     = 1'b1;
          issue_pc  = start_pc;
        end
      end
      RUN: begin
        if (redirect) begin
          issue    = 1'b1;
          issue_pc = redirect_pc;
        end else begin
          // Credit: buffered + arriving words must leave room for this read.
          issue = (({1'b0, fifo_count} + (CNT_W + 1)'(push)) < DEPTH_L);
          if (halt_ret) state_nxt = STOP;
        end
      end
      STOP: begin
        if (redirect) begin
          state_nxt = RUN;
          issue     = 1'b1;
          issue_pc  = redirect_pc;
        end else if (!has_head && !rd_vld) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      epoch    <= 1'b0;
      rd_vld   <= 1'b0;
      rd_epoch <= 1'b0;
      rd_pc    <= '0;
    end else begin
      state  <= state_nxt;
      rd_vld <= issue;
      if (redir_act) epoch <= ~epoch;
      if (issue) begin
        fetch_pc <= issue_pc + 1'b1;
        rd_pc    <= issue_pc;
        rd_epoch <= redir_act ? ~epoch : epoch;
      end
    end
  end

  bnn_fetch_fifo #(
    .DATA_W (INST_W),
    .PC_W   (ADDR_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (isram_rdata),
    .push_pc   (rd_pc),
    .pop       (pop),
    .flush     (redir_act),
    .head_data (head_inst),
    .head_pc   (head_pc),
    .count     (fifo_count)
  );

  assign isram_en   = issue;
  assign isram_addr = issue_pc;
  assign inst_valid = has_head;
  assign inst       = has_head ? head_inst : '0;
  assign inst_pc    = has_head ? head_pc : '0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_bnn_inst_fetch.sv
// Directed bench for bnn_inst_fetch: streaming, stall, redirect, reset,
// PC wrap and HALT, against a behavioural 1-cycle-latency SRAM.
module tb_bnn_inst_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] start_pc;
  logic        isram_en;
  logic [15:0] isram_addr;
  logic [15:0] isram_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic        halt_en;
  logic [15:0] halt_addr;

  int          done_cnt = 0;
  int          acc_n    = 0;
  int          n_rd     = 0;
  logic [15:0] acc_pc [256];
  logic [15:0] rd_last;

  bnn_inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_pc    (start_pc),
    .isram_en    (isram_en),
    .isram_addr  (isram_addr),
    .isram_rdata (isram_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: LOAD opcode (0x0800) tagged with the low address bits, HALT at halt_addr.
  function automatic logic [15:0] sram_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF800;
    return 16'h0800 | {5'b0, a[10:0]};
  endfunction

  always @(posedge clk) begin
    if (isram_en) isram_rdata <= sram_word(isram_addr);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (inst_valid && inst_ready && acc_n < 256) begin
      acc_pc[acc_n] = inst_pc;
      acc_n++;
    end
    if (isram_en) begin
      rd_last = isram_addr;
      n_rd++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int          acc_base;
  int          rd_base;
  int          done_base;
  logic        seen;
  logic [15:0] exp_pc;
  logic [15:0] wrap_inst [4];

  initial begin
    rst = 1'b1; start = 1'b0; start_pc = '0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt_en = 1'b0; halt_addr = '0;
    wrap_inst[0] = 16'h0FFE; wrap_inst[1] = 16'h0FFF;
    wrap_inst[2] = 16'h0800; wrap_inst[3] = 16'h0801;

    // reset values
    #12;
    chk("rst_isram_en", isram_en, 0);
    chk("rst_isram_addr", isram_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    rst = 1'b0;
    step();

    // stream from 0x0010, first word two cycles after start
    start = 1'b1; start_pc = 16'h0010; inst_ready = 1'b1;
    smp();
    chk("start_isram_en", isram_en, 1);
    chk("start_isram_addr", isram_addr, 16'h0010);
    step();
    start = 1'b0;
    smp();
    chk("lat1_valid", inst_valid, 0);
    chk("lat1_busy", busy, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      smp();
      exp_pc = 16'(16'h0010 + i);
      chk("stream_valid", inst_valid, 1);
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_inst", inst, 16'h0800 | exp_pc);
      step();
    end

    // decoder stall: FIFO fills to depth, then SRAM reads stop
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    smp();
    chk("stall_valid", inst_valid, 1);
    chk("stall_head_pc", inst_pc, 16'h0016);
    chk("stall_isram_en", isram_en, 0);
    chk("stall_last_read", rd_last, 16'h0019);
    step();
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      exp_pc = 16'(16'h0016 + i);
      chk("resume_valid", inst_valid, 1);
      chk("resume_pc", inst_pc, exp_pc);
      step();
    end

    // redirect issued together with the accept of the head word
    redirect = 1'b1; redirect_pc = 16'h0040;
    smp();
    chk("redir_head_pc", inst_pc, 16'h0020);
    chk("redir_isram_en", isram_en, 1);
    chk("redir_isram_addr", isram_addr, 16'h0040);
    step();
    redirect = 1'b0;
    smp();
    chk("redir_flush_valid", inst_valid, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      smp();
      exp_pc = 16'(16'h0040 + i);
      chk("redir_valid", inst_valid, 1);
      chk("redir_pc", inst_pc, exp_pc);
      chk("redir_inst", inst, 16'h0800 | exp_pc);
      step();
    end
    chk("redir_no_stale_pc", acc_pc[acc_n - 4], 16'h0020);

    // reset mid-stream with a full FIFO
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    smp();
    chk("full_valid", inst_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", inst_valid, 0);
    chk("midrst_inst", inst, 0);
    chk("midrst_inst_pc", inst_pc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_isram_en", isram_en, 0);
    chk("midrst_isram_addr", isram_addr, 0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_no_done", done_cnt, 0);

    // restart near the top of the address space: PC wraps
    start = 1'b1; start_pc = 16'hFFFE; inst_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      smp();
      exp_pc = 16'(16'hFFFE + i);
      chk("wrap_valid", inst_valid, 1);
      chk("wrap_pc", inst_pc, exp_pc);
      chk("wrap_inst", inst, wrap_inst[i]);
      step();
    end

    // HALT at 0x0005
    rst = 1'b1;
    step();
    rst = 1'b0;
    halt_en = 1'b1; halt_addr = 16'h0005;
    step();
    acc_base = acc_n; rd_base = n_rd; done_base = done_cnt;
    start = 1'b1; start_pc = 16'h0000;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      smp();
      if (done) seen = 1'b1;
      step();
    end
    chk("halt_done_seen", seen, 1);
    smp();
    chk("halt_busy", busy, 0);
    chk("halt_valid", inst_valid, 0);
    for (int i = 0; i < 5; i++) step();
    chk("halt_done_once", done_cnt - done_base, 1);
    chk("halt_n_delivered", acc_n - acc_base, 5);
    for (int i = 0; i < 5; i++)
      chk("halt_pc", acc_pc[acc_base + i], 16'(i));
    chk("halt_last_read", rd_last, 16'h0006);
    chk("halt_n_reads", n_rd - rd_base, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
